pc_stack_unit: RTL and testbench
================================

Name: pc_stack_unit

Overview:
- Parametrised next-generation program counter for the 8-bit CPU family; drives the instruction-memory address each cycle.
- Generalises the fixed 8-bit counter: configurable address width, absolute jump, and a hardware call/return stack of configurable depth.
- Reports stack overflow/underflow; optional vectored interrupt entry.
- Sits between the LUT decoder (control strobes) and instruction memory (ADDR).

Parameters:
AW, 8, address width in bits; ADDR wraps modulo 2^AW
DEPTH, 4, return-stack entries (2..16)
INT_VEC, 8'hF0, interrupt vector address, truncated to AW bits (used only with PC_INT_EN)

Ports:
CK  input  1  clock, all state updates on rising edge
RST_N  input  1  synchronous active-low reset
STALL  input  1  hold ADDR and stack unchanged this cycle
JMP  input  1  load ADDR from JMP_ADDR
CALL  input  1  push ADDR+1, load ADDR from JMP_ADDR
RET  input  1  pop top of stack into ADDR
JMP_ADDR  input  AW  jump/call target (from BUS)
INT_REQ  input  1  level interrupt request (PC_INT_EN only)
RETI  input  1  return from interrupt (PC_INT_EN only)
ADDR  output  AW  current instruction address (registered)
SP  output  clog2(DEPTH+1)  number of valid stack entries
STK_OVF  output  1  sticky: CALL attempted with SP==DEPTH
STK_UDF  output  1  sticky: RET attempted with SP==0
INT_ACK  output  1  one-cycle pulse when interrupt taken
IN_ISR  output  1  high from interrupt entry until RETI

Behaviour:
- Clock CK; reset synchronous, active-low (RST_N sampled on rising edge of CK).
- Reset: ADDR=0, SP=0, STK_OVF=0, STK_UDF=0, INT_ACK=0, IN_ISR=0; stack contents don't-care. Reset overrides every other input, including mid-call/mid-ISR.
- Per-cycle priority (one action per edge): reset > STALL > interrupt entry > RETI > RET > CALL > JMP > increment.
- Increment: ADDR <= ADDR+1 mod 2^AW (2^AW-1 wraps to 0, no flag).
- JMP: ADDR <= JMP_ADDR; stack untouched.
- CALL, SP<DEPTH: stack[SP] <= ADDR+1 (wrapped); SP <= SP+1; ADDR <= JMP_ADDR.
- CALL, SP==DEPTH: no push, no jump; ADDR increments; STK_OVF <= 1.
- RET, SP>0: ADDR <= stack[SP-1]; SP <= SP-1.
- RET, SP==0: ADDR increments; STK_UDF <= 1.
- STALL: all state held; no flag set even if a control strobe is asserted simultaneously.
- Latency: every action visible on ADDR the cycle after the edge; no combinational path from inputs to ADDR.
- STK_OVF/STK_UDF clear only on reset.
- Without PC_INT_EN: INT_REQ and RETI ignored; INT_ACK and IN_ISR tied 0.

Optional Feature:
- Macro PC_INT_EN.
- Defined:
  - Interrupt taken when INT_REQ=1, IN_ISR=0, STALL=0, SP<DEPTH.
  - On entry: stack[SP] <= ADDR (the current, unexecuted instruction, re-executed after return); SP+1; ADDR <= INT_VEC; IN_ISR <= 1; INT_ACK pulses 1 cycle.
  - If SP==DEPTH, the request stays pending (level) and no flag is set.
  - RETI with IN_ISR=1: pop as RET, IN_ISR <= 0. RETI with IN_ISR=0 is treated as RET.
  - Nested interrupts are blocked while IN_ISR=1.
- Undefined: no interrupt logic; outputs tied as above.

Test Plan:
- Reset/increment: RST_N=0 for 2 cycles, release with no strobes -> ADDR 0,1,2,…,255,0 (AW=8); SP=0, flags 0.
- Call/return: at ADDR=5 CALL with JMP_ADDR=0x40 -> ADDR=0x40, SP=1; 3 increments then RET -> ADDR=6, SP=0.
- Overflow: 4 nested CALLs (DEPTH=4) to 0x10,0x20,0x30,0x40 then CALL 0x50 -> ADDR=0x41, SP=4, STK_OVF=1; 4 RETs unwind to the pushed return addresses in LIFO order.
- Underflow and priority: RET with SP=0 at ADDR=9 -> ADDR=10, STK_UDF=1. CALL+JMP+RET together with SP=1, top=0x22 -> RET wins, ADDR=0x22. STALL with CALL -> ADDR/SP unchanged.
- Reset mid-operation: SP=3, STK_OVF=1, RST_N=0 one edge -> ADDR=0, SP=0, flags 0.
- PC_INT_EN: INT_REQ=1 at ADDR=0x12 -> ADDR=0xF0, INT_ACK 1 cycle, IN_ISR=1; INT_REQ held -> no re-entry; RETI -> ADDR=0x12, IN_ISR=0.

Source files
------------

// File: rtl/pc_stack_unit_if.sv
// Control/address bundle between the instruction decoder and pc_stack_unit.
// The decoder side uses the master modport and the program counter uses the slave modport.
interface pc_stack_unit_if #(
  parameter int AW    = 8,
  parameter int DEPTH = 4
);
  localparam int SPW = $clog2(DEPTH + 1);

  logic          STALL;
  logic          JMP;
  logic          CALL;
  logic          RET;
  logic [AW-1:0] JMP_ADDR;
  logic          INT_REQ;
  logic          RETI;
  logic [AW-1:0] ADDR;
  logic [SPW-1:0] SP;
  logic          STK_OVF;
  logic          STK_UDF;
  logic          INT_ACK;
  logic          IN_ISR;

  modport master (
    output STALL, JMP, CALL, RET, JMP_ADDR, INT_REQ, RETI,
    input  ADDR, SP, STK_OVF, STK_UDF, INT_ACK, IN_ISR
  );

  modport slave (
    input  STALL, JMP, CALL, RET, JMP_ADDR, INT_REQ, RETI,
    output ADDR, SP, STK_OVF, STK_UDF, INT_ACK, IN_ISR
  );
endinterface

// File: rtl/pc_stack_unit.sv
// Program counter with absolute jump, hardware call/return stack and sticky overflow/underflow flags.
// Define PC_INT_EN to add level-triggered vectored interrupt entry and RETI.
module pc_stack_unit #(
  parameter int            AW      = 8,
  parameter int            DEPTH   = 4,
  parameter logic [AW-1:0] INT_VEC = AW'(8'hF0)
) (
  input  logic           CK,
  input  logic           RST_N,
  pc_stack_unit_if.slave bus
);
  localparam int             SPW     = $clog2(DEPTH + 1);
  localparam int             IW      = $clog2(DEPTH);
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);
  localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
  localparam logic [SPW-1:0] SP_ZERO = SPW'(0);

  logic [AW-1:0]  addr_r;
  logic [AW-1:0]  addr_nxt_s;
  logic [AW-1:0]  addr_inc_s;
  logic [AW-1:0]  top_s;
  logic [AW-1:0]  push_data_s;
  logic [SPW-1:0] sp_r;
  logic [SPW-1:0] sp_nxt_s;
  logic           ovf_r;
  logic           ovf_nxt_s;
  logic           udf_r;
  logic           udf_nxt_s;
  logic           ack_r;
  logic           ack_nxt_s;
  logic           isr_r;
  logic           isr_nxt_s;
  logic           push_s;
  logic           full_s;
  logic           empty_s;
  logic           take_int_s;
  logic           reti_s;
  logic           ret_s;
  logic [AW-1:0]  stack_r [DEPTH];

  assign addr_inc_s = addr_r + AW'(1);
  assign full_s     = (sp_r == SP_FULL);
  assign empty_s    = (sp_r == SP_ZERO);
  assign top_s      = stack_r[IW'(sp_r - SP_ONE)];

`ifdef PC_INT_EN
  // Interrupt entry needs a free stack slot; otherwise the level request simply waits.
  assign take_int_s = bus.INT_REQ & ~isr_r & ~full_s;
  assign reti_s     = bus.RETI;
`else
  logic unused_int_s;
  assign take_int_s   = 1'b0;
  assign reti_s       = 1'b0;
  assign unused_int_s = bus.INT_REQ ^ bus.RETI;
`endif

  assign ret_s = bus.RET | reti_s;

  // Next-state selection: one action per edge in priority order.
  always_comb begin
    addr_nxt_s  = addr_r;
    sp_nxt_s    = sp_r;
    ovf_nxt_s   = ovf_r;
    udf_nxt_s   = udf_r;
    ack_nxt_s   = 1'b0;
    isr_nxt_s   = isr_r;
    push_s      = 1'b0;
    push_data_s = addr_r;
    if (bus.STALL) begin
      addr_nxt_s = addr_r;
    end else if (take_int_s) begin
      // The interrupted instruction has not executed yet, so it is saved for re-execution.
      push_s      = 1'b1;
      push_data_s = addr_r;
      sp_nxt_s    = sp_r + SP_ONE;
      addr_nxt_s  = INT_VEC;
      isr_nxt_s   = 1'b1;
      ack_nxt_s   = 1'b1;
    end else if (ret_s) begin
      if (empty_s) begin
        addr_nxt_s = addr_inc_s;
        udf_nxt_s  = 1'b1;
      end else begin
        addr_nxt_s = top_s;
        sp_nxt_s   = sp_r - SP_ONE;
      end
      if (reti_s) begin
        isr_nxt_s = 1'b0;
      end else begin
        isr_nxt_s = isr_r;
      end
    end else if (bus.CALL) begin
      if (full_s) begin
        addr_nxt_s = addr_inc_s;
        ovf_nxt_s  = 1'b1;
      end else begin
        push_s      = 1'b1;
        push_data_s = addr_inc_s;
        sp_nxt_s    = sp_r + SP_ONE;
        addr_nxt_s  = bus.JMP_ADDR;
      end
    end else if (bus.JMP) begin
      addr_nxt_s = bus.JMP_ADDR;
    end else begin
      addr_nxt_s = addr_inc_s;
    end
  end

  // Architectural state register with synchronous active-low reset.
  always_ff @(posedge CK) begin
    if (!RST_N) begin
      addr_r <= {AW{1'b0}};
      sp_r   <= SP_ZERO;
      ovf_r  <= 1'b0;
      udf_r  <= 1'b0;
      ack_r  <= 1'b0;
      isr_r  <= 1'b0;
    end else begin
      addr_r <= addr_nxt_s;
      sp_r   <= sp_nxt_s;
      ovf_r  <= ovf_nxt_s;
      udf_r  <= udf_nxt_s;
      ack_r  <= ack_nxt_s;
      isr_r  <= isr_nxt_s;
    end
  end

  // Return-stack storage; contents are don't-care after reset so it carries no reset.
  always_ff @(posedge CK) begin
    if (RST_N && push_s) begin
      stack_r[IW'(sp_r)] <= push_data_s;
    end else begin
      stack_r <= stack_r;
    end
  end

  assign bus.ADDR    = addr_r;
  assign bus.SP      = sp_r;
  assign bus.STK_OVF = ovf_r;
  assign bus.STK_UDF = udf_r;
  assign bus.INT_ACK = ack_r;
  assign bus.IN_ISR  = isr_r;
endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit: queue-based reference model checked every cycle,
// plus hand-computed literal expectations at the points of interest.
module tb_pc_stack_unit;
  localparam int AW    = 8;
  localparam int DEPTH = 4;
  localparam int MOD   = 256;
  localparam int VEC   = 32'h0000_00F0;

  logic CK;
  logic RST_N;

  pc_stack_unit_if #(.AW(AW), .DEPTH(DEPTH)) bus ();

  pc_stack_unit #(.AW(AW), .DEPTH(DEPTH), .INT_VEC(8'hF0)) dut (
    .CK   (CK),
    .RST_N(RST_N),
    .bus  (bus.slave)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // reference model state
  int m_addr = 0;
  int m_stk[$];
  bit m_ovf = 1'b0;
  bit m_udf = 1'b0;
  bit m_ack = 1'b0;
  bit m_isr = 1'b0;

`ifdef PC_INT_EN
  localparam bit INT_EN = 1'b1;
`else
  localparam bit INT_EN = 1'b0;
`endif

  task automatic model_step();
    bit reti_eff;
    reti_eff = INT_EN && (bus.RETI === 1'b1);
    if (RST_N !== 1'b1) begin
      m_addr = 0; m_stk.delete(); m_ovf = 0; m_udf = 0; m_ack = 0; m_isr = 0;
    end else if (bus.STALL) begin
      m_ack = 0;
    end else if (INT_EN && bus.INT_REQ && !m_isr && m_stk.size() < DEPTH) begin
      m_stk.push_back(m_addr);
      m_addr = VEC;
      m_isr  = 1;
      m_ack  = 1;
    end else begin
      m_ack = 0;
      if (bus.RET || reti_eff) begin
        if (m_stk.size() > 0) m_addr = m_stk.pop_back();
        else begin m_addr = (m_addr + 1) % MOD; m_udf = 1; end
        if (reti_eff) m_isr = 0;
      end else if (bus.CALL) begin
        if (m_stk.size() < DEPTH) begin
          m_stk.push_back((m_addr + 1) % MOD);
          m_addr = int'(bus.JMP_ADDR);
        end else begin
          m_addr = (m_addr + 1) % MOD;
          m_ovf  = 1;
        end
      end else if (bus.JMP) begin
        m_addr = int'(bus.JMP_ADDR);
      end else begin
        m_addr = (m_addr + 1) % MOD;
      end
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge CK) begin
    if (chk_en) begin
      n_tests++;
      if (bus.ADDR !== AW'(m_addr) || int'(bus.SP) != m_stk.size() ||
          bus.STK_OVF !== m_ovf || bus.STK_UDF !== m_udf ||
          bus.INT_ACK !== m_ack || bus.IN_ISR !== m_isr) begin
        n_fail++;
        $display("FAIL cycle_model t=%0t: got ADDR=%0h SP=%0d OVF=%0b UDF=%0b ACK=%0b ISR=%0b, want ADDR=%0h SP=%0d OVF=%0b UDF=%0b ACK=%0b ISR=%0b",
                 $time, bus.ADDR, bus.SP, bus.STK_OVF, bus.STK_UDF, bus.INT_ACK, bus.IN_ISR,
                 m_addr, m_stk.size(), m_ovf, m_udf, m_ack, m_isr);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit rst_n, input bit stall, input bit jmp, input bit call,
                       input bit ret, input logic [AW-1:0] ja, input bit irq, input bit reti);
    RST_N        = rst_n;
    bus.STALL    = stall;
    bus.JMP      = jmp;
    bus.CALL     = call;
    bus.RET      = ret;
    bus.JMP_ADDR = ja;
    bus.INT_REQ  = irq;
    bus.RETI     = reti;
    @(posedge CK);
    model_step();
    @(negedge CK);
  endtask

  task automatic inc(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 8'h00, 0, 0);
  endtask
  task automatic jmp_to(input logic [AW-1:0] a);  drive(1, 0, 1, 0, 0, a, 0, 0); endtask
  task automatic call_to(input logic [AW-1:0] a); drive(1, 0, 0, 1, 0, a, 0, 0); endtask
  task automatic do_ret();                        drive(1, 0, 0, 0, 1, 8'h00, 0, 0); endtask

  initial begin
    @(negedge CK);
    drive(0, 0, 0, 0, 0, 8'h00, 0, 0);
    chk_en = 1'b1;
    drive(0, 0, 0, 0, 0, 8'h00, 0, 0);
    chk("reset_addr", int'(bus.ADDR), 0);
    chk("reset_sp", int'(bus.SP), 0);
    chk("reset_flags", int'({bus.STK_OVF, bus.STK_UDF, bus.INT_ACK, bus.IN_ISR}), 0);

    inc(255);
    chk("inc_255", int'(bus.ADDR), 255);
    inc(1);
    chk("inc_wrap", int'(bus.ADDR), 0);

    jmp_to(8'h05);
    chk("jmp_5", int'(bus.ADDR), 5);
    call_to(8'h40);
    chk("call_addr", int'(bus.ADDR), 8'h40);
    chk("call_sp", int'(bus.SP), 1);
    inc(3);
    do_ret();
    chk("ret_addr", int'(bus.ADDR), 6);
    chk("ret_sp", int'(bus.SP), 0);

    call_to(8'h10); call_to(8'h20); call_to(8'h30); call_to(8'h40);
    chk("nest_sp", int'(bus.SP), 4);
    call_to(8'h50);
    chk("ovf_addr", int'(bus.ADDR), 8'h41);
    chk("ovf_sp", int'(bus.SP), 4);
    chk("ovf_flag", int'(bus.STK_OVF), 1);
    do_ret(); chk("unwind_1", int'(bus.ADDR), 8'h31);
    do_ret(); chk("unwind_2", int'(bus.ADDR), 8'h21);
    do_ret(); chk("unwind_3", int'(bus.ADDR), 8'h11);
    do_ret(); chk("unwind_4", int'(bus.ADDR), 8'h07);
    chk("udf_still_clear", int'(bus.STK_UDF), 0);

    jmp_to(8'h09);
    do_ret();
    chk("udf_addr", int'(bus.ADDR), 8'h0A);
    chk("udf_flag", int'(bus.STK_UDF), 1);

    jmp_to(8'h21);
    call_to(8'h60);
    drive(1, 0, 1, 1, 1, 8'h77, 0, 0);
    chk("prio_ret_addr", int'(bus.ADDR), 8'h22);
    chk("prio_ret_sp", int'(bus.SP), 0);

    drive(1, 1, 0, 1, 0, 8'h55, 0, 0);
    chk("stall_addr", int'(bus.ADDR), 8'h22);
    chk("stall_sp", int'(bus.SP), 0);

    call_to(8'h10); call_to(8'h20); call_to(8'h30);
    chk("pre_rst_sp", int'(bus.SP), 3);
    drive(0, 0, 0, 1, 0, 8'h44, 0, 0);
    chk("midrst_addr", int'(bus.ADDR), 0);
    chk("midrst_sp", int'(bus.SP), 0);
    chk("midrst_flags", int'({bus.STK_OVF, bus.STK_UDF}), 0);
    inc(1);
    chk("post_rst_inc", int'(bus.ADDR), 1);

`ifdef PC_INT_EN
    jmp_to(8'h12);
    drive(1, 0, 0, 0, 0, 8'h00, 1, 0);
    chk("int_addr", int'(bus.ADDR), 8'hF0);
    chk("int_ack", int'(bus.INT_ACK), 1);
    chk("int_isr", int'(bus.IN_ISR), 1);
    drive(1, 0, 0, 0, 0, 8'h00, 1, 0);
    chk("int_no_reentry", int'(bus.ADDR), 8'hF1);
    chk("int_ack_pulse", int'(bus.INT_ACK), 0);
    drive(1, 0, 0, 0, 0, 8'h00, 0, 1);
    chk("reti_addr", int'(bus.ADDR), 8'h12);
    chk("reti_isr", int'(bus.IN_ISR), 0);
    call_to(8'h10); call_to(8'h20); call_to(8'h30); call_to(8'h40);
    drive(1, 0, 0, 0, 0, 8'h00, 1, 0);
    chk("int_pending_full", int'(bus.ADDR), 8'h41);
    chk("int_pending_noflag", int'(bus.STK_OVF), 0);
`else
    drive(1, 0, 0, 0, 0, 8'h00, 1, 1);
    chk("noint_ignored", int'(bus.ADDR), 2);
    chk("noint_outputs", int'({bus.INT_ACK, bus.IN_ISR}), 0);
`endif

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
